min_hr_cntr: RTL and testbench
==============================

# min_hr_cntr

Minute/hour timekeeping block that consumes the one-cycle `f_1min` flag from the seconds counter and maintains 24-hour time. It sits directly downstream of the seconds counter in the clock datapath and shares its `clk_1sec` domain. It supports the following:
- A four-phase time-set handshake from the button/UI controller.
- BCD display outputs for the seven-segment drivers.
- A day-rollover flag.
- An alarm that rings for a bounded number of minutes.

## Interface
Parameters:
- `RING_MINUTES`, default 5: number of minute increments after which an active alarm self-clears. Legal range is 1–15.

Ports:
- `clk_1sec` input, 1 bit: 1 Hz clock, rising-edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `f_1min` input, 1 bit: high for one `clk_1sec` cycle when 59 s have elapsed. Each sampled-high edge means exactly one minute increment.
- `set_valid` input, 1 bit: time-set request (four-phase handshake).
- `set_hr` input, 5 bits: binary hour to load. Legal range 0–23.
- `set_min` input, 6 bits: binary minute to load. Legal range 0–59.
- `set_ack` output, 1 bit: legal load accepted. Held high until `set_valid` drops.
- `set_err` output, 1 bit: illegal load rejected. Held high until `set_valid` drops.
- `alarm_en` input, 1 bit: alarm arm. Low immediately clears ringing.
- `alarm_hr` input, 5 bits: binary alarm hour.
- `alarm_min` input, 6 bits: binary alarm minute.
- `alarm_clr` input, 1 bit: user dismiss. Synchronous clear of ringing.
- `alarm_ring` output, 1 bit: alarm active.
- `min_bcd` output, 8 bits: {tens, ones} of minute. Tens digit occupies bits [7:4], range 0–5.
- `hr_bcd` output, 8 bits: {tens, ones} of hour. Tens digit range 0–2.
- `f_1day` output, 1 bit: one-cycle pulse on the 23:59→00:00 rollover.

## Operation
Internal state:
- Binary `hr_q` (5 bits) and `min_q` (6 bits).
- State register, with states `RUN`, `ACK`, `ERR`.
- Ring counter, 4 bits.

Counting, in `RUN` with `f_1min` high and `set_valid` low:
- `min_q` increments.
- When `min_q`==59: `min_q` goes to 0 and `hr_q` increments.
- When `hr_q`==23 as well: `hr_q` goes to 0 and `f_1day` is 1 for that cycle only.

Set handshake:
- In `RUN` with `set_valid` high and `set_hr`≤23 and `set_min`≤59:
  - Load both registers on that edge.
  - Go to `ACK`; `set_ack` goes to 1.
- If either field is illegal:
  - Time is unchanged.
  - Go to `ERR`; `set_err` goes to 1.
- `ACK`/`ERR` return to `RUN` on the first edge where `set_valid` is low, clearing `set_ack`/`set_err`.
- While in `ACK`/`ERR`, `f_1min` is ignored: time is frozen and minutes are dropped, not queued.

Simultaneous events:
- `set_valid` high with `f_1min` high in `RUN`: the set wins and the increment is dropped.
- Illegal set with `f_1min` high: the increment is also dropped.

Alarm:
- The compare is evaluated only on counting increments, never on a load.
- When the post-increment time equals {`alarm_hr`, `alarm_min`} and `alarm_en` is 1: `alarm_ring` goes to 1 and the ring counter is cleared to 0.
- While ringing, each counted increment adds 1 to the ring counter. When the counter reaches `RING_MINUTES`, `alarm_ring` goes to 0 on that edge.
- `alarm_clr` high or `alarm_en` low forces `alarm_ring` to 0 on the next edge.
- Clear has priority over a simultaneous new match.

BCD:
- `min_bcd` and `hr_bcd` are a combinational conversion of the registered binary values.

## Timing
Reset values:
- `min_q`=0, `hr_q`=0, state=`RUN`, ring counter=0.
- `set_ack`=0, `set_err`=0, `alarm_ring`=0, `f_1day`=0.
- Therefore `min_bcd`=8'h00 and `hr_bcd`=8'h00.

Latency:
- An increment is visible on outputs one edge after `f_1min` is sampled high.
- Load and `set_ack`/`set_err` are visible one edge after `set_valid` is sampled.
- Alarm ring is visible on the same edge as the matching increment.

Registered vs. combinational outputs:
- All outputs except the BCD outputs are registered.
- The BCD outputs are combinational from registers, so they change only after clock edges.

Reset mid-handshake:
- Returns to `RUN` with `set_ack` at 0.
- If `set_valid` is still high after reset release, it is treated as a new request.

## Structure
- The package `clock_pkg` holds:
  - Constants `MAX_MIN`=59 and `MAX_HR`=23.
  - The `set_state_t` enum {`RUN`, `ACK`, `ERR`}.
  - The BCD digit typedef.
- Sub-module `bin_to_bcd60`: combinational converter from a 6-bit binary value in 0–59 to 8-bit packed BCD. It is instantiated twice, with the hour zero-extended.

## Test plan
- Reset, then 61 `f_1min` pulses: output is `hr_bcd`=8'h01 and `min_bcd`=8'h01.
- Load 23:59 legally, then `set_ack` goes high; drop `set_valid`, then one `f_1min`: output is 00:00 with `f_1day` high for exactly one cycle.
- `set_valid` with `set_min`=60: `set_err` goes high, time is unchanged, and `f_1min` is ignored until `set_valid` drops.
- `set_valid` (legal 10:15) and `f_1min` high on the same edge: time is exactly 10:15, with no increment.
- Alarm 07:00 armed and time counted from 06:59:
  - `alarm_ring` rises at 07:00.
  - It falls on the 5th subsequent `f_1min`, at 07:05.
  - Repeat the run with `alarm_clr` asserted at 07:02: ring drops on the next edge.
- Assert `reset_n` low while in `ACK` with time 12:34: all outputs read zero immediately, asynchronously.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and limits for the minute/hour timekeeping slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package clock_pkg;

  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [4:0] MAX_HR  = 5'd23;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    ACK = 2'd1,
    ERR = 2'd2
  } set_state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bin_to_bcd60.sv
// Converts a binary value in 0..59 to packed two-digit BCD {tens, ones}.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module bin_to_bcd60
  import clock_pkg::*;
(
  input  logic [5:0] bin,
  output logic [7:0] bcd
);

  bcd_digit_t tens;
  bcd_digit_t ones;
  logic [5:0] base;

  // Pick the tens digit by range, then take the remainder for the ones digit.
  always_comb begin
    tens = 4'd0;
    base = 6'd0;
    if (bin >= 6'd50) begin
      tens = 4'd5;
      base = 6'd50;
    end else if (bin >= 6'd40) begin
      tens = 4'd4;
      base = 6'd40;
    end else if (bin >= 6'd30) begin
      tens = 4'd3;
      base = 6'd30;
    end else if (bin >= 6'd20) begin
      tens = 4'd2;
      base = 6'd20;
    end else if (bin >= 6'd10) begin
      tens = 4'd1;
      base = 6'd10;
    end
    // Remainder is always below 10, so the low nibble carries it exactly.
    ones = 4'(bin - base);
    bcd  = {tens, ones};
  end

endmodule

// File: rtl/min_hr_cntr.sv
// 24-hour minute/hour counter with time-set handshake, day pulse and bounded alarm.
// Latency: increments, loads and handshake responses appear one clk_1sec edge after sampling.
// Backpressure: while a set is acknowledged/rejected, f_1min is dropped until set_valid falls.
module min_hr_cntr
  import clock_pkg::*;
#(
  parameter int RING_MINUTES = 5
) (
  input  logic       clk_1sec,
  input  logic       reset_n,
  input  logic       f_1min,
  input  logic       set_valid,
  input  logic [4:0] set_hr,
  input  logic [5:0] set_min,
  output logic       set_ack,
  output logic       set_err,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hr,
  input  logic [5:0] alarm_min,
  input  logic       alarm_clr,
  output logic       alarm_ring,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       f_1day
);

  localparam logic [3:0] RING_LIMIT = 4'(RING_MINUTES);

  set_state_t state_q, state_d;
  logic [4:0] hr_q;
  logic [5:0] min_q;
  logic [3:0] ring_cnt_q;
  logic       ring_q;
  logic       day_q;

  logic       set_legal;
  logic       load_en;
  logic       count_en;
  logic       wrap_min;
  logic       wrap_day;
  logic [5:0] min_inc;
  logic [4:0] hr_inc;
  logic [3:0] ring_cnt_inc;
  logic       alarm_hit;

  // Decode load/count qualifiers and the post-increment time used by the alarm compare.
  always_comb begin
    set_legal    = (set_hr <= MAX_HR) && (set_min <= MAX_MIN);
    load_en      = (state_q == RUN) && set_valid && set_legal;
    count_en     = (state_q == RUN) && !set_valid && f_1min;
    wrap_min     = (min_q == MAX_MIN);
    wrap_day     = wrap_min && (hr_q == MAX_HR);
    min_inc      = wrap_min ? 6'd0 : (min_q + 6'd1);
    hr_inc       = hr_q;
    if (wrap_min) begin
      hr_inc = wrap_day ? 5'd0 : (hr_q + 5'd1);
    end
    ring_cnt_inc = ring_cnt_q + 4'd1;
    alarm_hit    = alarm_en && (hr_inc == alarm_hr) && (min_inc == alarm_min);
  end

  // Handshake state register.
  always_ff @(posedge clk_1sec or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake next state: a request is judged once in RUN, then held until set_valid drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (set_valid) begin
          state_d = set_legal ? ACK : ERR;
        end
      end
      ACK, ERR: begin
        if (!set_valid) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Time registers: a legal load beats a coincident minute tick; ticks outside RUN are lost.
  always_ff @(posedge clk_1sec or negedge reset_n) begin
    if (!reset_n) begin
      hr_q  <= 5'd0;
      min_q <= 6'd0;
      day_q <= 1'b0;
    end else begin
      day_q <= 1'b0;
      if (load_en) begin
        hr_q  <= set_hr;
        min_q <= set_min;
      end else if (count_en) begin
        hr_q  <= hr_inc;
        min_q <= min_inc;
        day_q <= wrap_day;
      end
    end
  end

  // Alarm: dismiss/disarm wins, then a fresh match restarts, else count rung minutes.
  always_ff @(posedge clk_1sec or negedge reset_n) begin
    if (!reset_n) begin
      ring_q     <= 1'b0;
      ring_cnt_q <= 4'd0;
    end else if (alarm_clr || !alarm_en) begin
      ring_q <= 1'b0;
    end else if (count_en && alarm_hit) begin
      ring_q     <= 1'b1;
      ring_cnt_q <= 4'd0;
    end else if (count_en && ring_q) begin
      ring_cnt_q <= ring_cnt_inc;
      if (ring_cnt_inc == RING_LIMIT) begin
        ring_q <= 1'b0;
      end
    end
  end

  assign set_ack    = (state_q == ACK);
  assign set_err    = (state_q == ERR);
  assign alarm_ring = ring_q;
  assign f_1day     = day_q;

  bin_to_bcd60 u_min_bcd (
    .bin (min_q),
    .bcd (min_bcd)
  );

  bin_to_bcd60 u_hr_bcd (
    .bin ({1'b0, hr_q}),
    .bcd (hr_bcd)
  );

endmodule

// File: tb/tb_min_hr_cntr.sv
// Self-checking bench for min_hr_cntr: directed table, corner sequences, random vs model.
// Latency: checks one edge after each applied input set.
// Backpressure: exercises dropped minutes during held handshakes.
module tb_min_hr_cntr;

  localparam int RING = 5;

  logic       clk_1sec;
  logic       reset_n;
  logic       f_1min;
  logic       set_valid;
  logic [4:0] set_hr;
  logic [5:0] set_min;
  logic       set_ack;
  logic       set_err;
  logic       alarm_en;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       alarm_clr;
  logic       alarm_ring;
  logic [7:0] min_bcd;
  logic [7:0] hr_bcd;
  logic       f_1day;

  min_hr_cntr #(.RING_MINUTES(RING)) dut (
    .clk_1sec   (clk_1sec),
    .reset_n    (reset_n),
    .f_1min     (f_1min),
    .set_valid  (set_valid),
    .set_hr     (set_hr),
    .set_min    (set_min),
    .set_ack    (set_ack),
    .set_err    (set_err),
    .alarm_en   (alarm_en),
    .alarm_hr   (alarm_hr),
    .alarm_min  (alarm_min),
    .alarm_clr  (alarm_clr),
    .alarm_ring (alarm_ring),
    .min_bcd    (min_bcd),
    .hr_bcd     (hr_bcd),
    .f_1day     (f_1day)
  );

  initial clk_1sec = 1'b0;
  always #5 clk_1sec = ~clk_1sec;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time as minute-of-day, handshake as 0=idle 1=accepted 2=rejected.
  int m_t, m_mode, m_rc;
  bit m_ring, m_day;

  logic [19:0] dut_vec;
  assign dut_vec = {hr_bcd, min_bcd, set_ack, set_err, alarm_ring, f_1day};

  function automatic logic [19:0] exp_vec();
    int h, m;
    h = m_t / 60;
    m = m_t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            (m_mode == 1), (m_mode == 2), m_ring, m_day};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hr=%h min=%h ack=%b err=%b ring=%b day=%b, want hr=%h min=%h ack=%b err=%b ring=%b day=%b",
               name, act[19:12], act[11:4], act[3], act[2], act[1], act[0],
               exp[19:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_rc = 0; m_ring = 0; m_day = 0;
  endtask

  // Apply the rules of one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    bit counted;
    counted = 0;
    m_day   = 0;
    if (m_mode == 0) begin
      if (set_valid) begin
        if (set_hr <= 23 && set_min <= 59) begin
          m_t    = int'(set_hr) * 60 + int'(set_min);
          m_mode = 1;
        end else begin
          m_mode = 2;
        end
      end else if (f_1min) begin
        counted = 1;
      end
    end else if (!set_valid) begin
      m_mode = 0;
    end
    if (counted) begin
      if (m_t == 1439) m_day = 1;
      m_t = (m_t + 1) % 1440;
    end
    if (alarm_clr || !alarm_en) begin
      m_ring = 0;
    end else if (counted && (m_t / 60 == int'(alarm_hr)) && (m_t % 60 == int'(alarm_min))) begin
      m_ring = 1;
      m_rc   = 0;
    end else if (counted && m_ring) begin
      m_rc++;
      if (m_rc == RING) m_ring = 0;
    end
  endtask

  // Called at posedge+1: pulse reset asynchronously and check zeroed outputs mid-cycle.
  task automatic do_reset(input string name);
    reset_n = 1'b0;
    model_reset();
    #1;
    check(name, dut_vec, 20'h0);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic tick(input string name);
    @(posedge clk_1sec);
    model_edge();
    #1;
    check(name, dut_vec, exp_vec());
  endtask

  task automatic drive(input logic f, input logic sv, input logic [4:0] sh, input logic [5:0] sm);
    f_1min = f; set_valid = sv; set_hr = sh; set_min = sm;
  endtask

  typedef struct {
    logic       f;
    logic       sv;
    logic [4:0] sh;
    logic [5:0] sm;
    logic [7:0] e_hr;
    logic [7:0] e_min;
    logic       e_ack;
    logic       e_err;
    logic       e_day;
  } vec_t;

  vec_t tbl[16];

  initial begin
    reset_n = 1'b0;
    f_1min = 0; set_valid = 0; set_hr = 0; set_min = 0;
    alarm_en = 0; alarm_hr = 0; alarm_min = 0; alarm_clr = 0;
    model_reset();

    //         f  sv  sh     sm     hr     min    ack err day
    tbl[0]  = '{1'b0, 1'b1, 5'd23, 6'd59, 8'h23, 8'h59, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 5'd23, 6'd59, 8'h23, 8'h59, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 5'd0,  6'd0,  8'h23, 8'h59, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 5'd0,  6'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 5'd0,  6'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 5'd3,  6'd60, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 5'd3,  6'd60, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  6'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 5'd0,  6'd0,  8'h00, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 5'd10, 6'd15, 8'h10, 8'h15, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 5'd0,  6'd0,  8'h10, 8'h15, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 5'd0,  6'd0,  8'h10, 8'h16, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 5'd24, 6'd0,  8'h10, 8'h16, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  6'd0,  8'h10, 8'h16, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 5'd0,  6'd0,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 5'd0,  6'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

    #1;
    do_reset("reset_initial");

    // Directed handshake/rollover table.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].f, tbl[i].sv, tbl[i].sh, tbl[i].sm);
      @(posedge clk_1sec);
      model_edge();
      #1;
      check($sformatf("table_%0d", i), dut_vec,
            {tbl[i].e_hr, tbl[i].e_min, tbl[i].e_ack, tbl[i].e_err, 1'b0, tbl[i].e_day});
    end

    // 61 minutes from reset lands on 01:01.
    do_reset("reset_count61");
    for (int i = 0; i < 61; i++) begin
      drive(1, 0, 0, 0);
      tick("count61_step");
    end
    check("count61_final", dut_vec, {8'h01, 8'h01, 4'b0000});

    // Alarm at 07:00 rings through 07:04 and self-clears at 07:05.
    alarm_en = 1; alarm_hr = 5'd7; alarm_min = 6'd0;
    drive(0, 1, 5'd6, 6'd59); tick("alarm_load");
    drive(0, 0, 0, 0);        tick("alarm_release");
    drive(1, 0, 0, 0);        tick("alarm_0700");
    check_bit("alarm_rise_0700", alarm_ring, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick("alarm_hold");
      check_bit($sformatf("alarm_still_on_%0d", i), alarm_ring, 1'b1);
    end
    tick("alarm_0705");
    check_bit("alarm_self_clear_0705", alarm_ring, 1'b0);
    check("alarm_time_0705", dut_vec, {8'h07, 8'h05, 4'b0000});

    // Same run, dismissed at 07:02.
    drive(0, 1, 5'd6, 6'd59); tick("alarm2_load");
    drive(0, 0, 0, 0);        tick("alarm2_release");
    drive(1, 0, 0, 0);        tick("alarm2_0700");
    tick("alarm2_0701");
    tick("alarm2_0702");
    check_bit("alarm2_on_0702", alarm_ring, 1'b1);
    drive(0, 0, 0, 0); alarm_clr = 1;
    tick("alarm2_clr");
    check_bit("alarm2_dismissed", alarm_ring, 1'b0);
    alarm_clr = 0; alarm_en = 0;

    // Reset while acknowledged at 12:34, request still held afterwards.
    drive(0, 1, 5'd12, 6'd34); tick("ack_1234");
    check("ack_1234_direct", dut_vec, {8'h12, 8'h34, 4'b1000});
    do_reset("async_reset_in_ack");
    tick("rerequest_after_reset");
    drive(0, 0, 0, 0); tick("rerequest_release");

    // Randomised traffic against the model.
    begin
      logic [4:0] r_hr;
      logic [5:0] r_min;
      bit         held;
      held = 0; r_hr = 0; r_min = 0;
      for (int c = 0; c < 4000; c++) begin
        if (c % 150 == 0) begin
          alarm_hr  = 5'(m_t / 60);
          alarm_min = 6'((m_t % 60 + int'($urandom_range(1, 6))) % 60);
        end
        if ($urandom_range(0, 7) == 0) begin
          held = !held;
          if (held) begin
            r_hr  = 5'($urandom_range(0, 26));
            r_min = 6'($urandom_range(0, 63));
          end
        end
        drive(1'($urandom_range(0, 1)), held, r_hr, r_min);
        alarm_en  = ($urandom_range(0, 15) != 0);
        alarm_clr = ($urandom_range(0, 31) == 0);
        tick("random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
